// File: rtl/sign_deduct_pkg.sv
// Shared widths and defaults for the sign/magnitude deduction scheduler.
package sign_deduct_pkg;

    localparam int COORD_W   = 12;
    localparam int N_REQ_DEF = 4;
    localparam int ID_W      = $clog2(N_REQ_DEF);

endpackage

// File: rtl/sign_deduct_core.sv
// Combinational |coord - offset| with an unsigned-compare sign flag.
module sign_deduct_core
    import sign_deduct_pkg::*;
#(
    parameter int W = COORD_W
) (
    input  logic [W-1:0] coord,
    input  logic [W-1:0] offset,
    output logic [W-1:0] mag,
    output logic         sign
);

    always_comb begin
        sign = (coord < offset);
        mag  = sign ? (offset - coord) : (coord - offset);
    end

endmodule

// File: rtl/sign_deduct_sched.sv
// Round-robin scheduler sharing one deduction core among N_REQ requesters
// through a two-stage pipeline (issue/operand capture, result register).
module sign_deduct_sched
    import sign_deduct_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = COORD_W
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W-1:0]       coord,
    input  logic [N_REQ*W-1:0]       offset,
    output logic [N_REQ-1:0]         done,
    output logic                     res_valid,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [W-1:0]             res_mag,
    output logic                     res_sign,
    output logic                     busy
);

    localparam int SEL_W = $clog2(N_REQ);

    logic [SEL_W-1:0] r_ptr;
    logic [N_REQ-1:0] r_inflight;

    logic             r_v1;
    logic [SEL_W-1:0] r_id1;
    logic [W-1:0]     r_coord1;
    logic [W-1:0]     r_offset1;

    logic             r_v2;
    logic [SEL_W-1:0] r_id2;
    logic [W-1:0]     r_mag2;
    logic             r_sign2;

    logic [N_REQ-1:0] w_elig;
    logic             w_found;
    logic [SEL_W-1:0] w_win;
    logic [SEL_W-1:0] w_idx;
    logic [N_REQ-1:0] w_set;
    logic [N_REQ-1:0] w_done;
    logic [W-1:0]     w_mag;
    logic             w_sign;

    assign w_elig = req & ~r_inflight;

    // Scan from the farthest offset down so the one closest to r_ptr wins;
    // the index wraps naturally because N_REQ is a power of two.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = r_ptr + SEL_W'(k);
            if (w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_set  = w_found ? (N_REQ'(1) << w_win) : '0;
    assign w_done = r_v2 ? (N_REQ'(1) << r_id2) : '0;

    sign_deduct_core #(.W(W)) u_core (
        .coord  (r_coord1),
        .offset (r_offset1),
        .mag    (w_mag),
        .sign   (w_sign)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_ptr      <= '0;
            r_inflight <= '0;
            r_v1       <= 1'b0;
            r_id1      <= '0;
            r_coord1   <= '0;
            r_offset1  <= '0;
            r_v2       <= 1'b0;
            r_id2      <= '0;
            r_mag2     <= '0;
            r_sign2    <= 1'b0;
        end else begin
            // Issue stage: completion clears and the new issue can land on the same edge.
            r_inflight <= (r_inflight & ~w_done) | w_set;
            r_v1       <= w_found;
            r_id1      <= w_win;
            r_coord1   <= coord[w_win*W +: W];
            r_offset1  <= offset[w_win*W +: W];
            if (w_found) begin
                r_ptr <= w_win + SEL_W'(1);
            end
            // Result stage
            r_v2    <= r_v1;
            r_id2   <= r_id1;
            r_mag2  <= w_mag;
            r_sign2 <= w_sign;
        end
    end

    assign done      = w_done;
    assign res_valid = r_v2;
    assign res_id    = r_id2;
    assign res_mag   = r_mag2;
    assign res_sign  = r_sign2;
    assign busy      = |r_inflight;

endmodule

// File: tb/tb_sign_deduct_sched.sv
// Directed bench for sign_deduct_sched with hand-computed expectations.
module tb_sign_deduct_sched;

    logic        CLOCK;
    logic        RESET;
    logic [3:0]  req;
    logic [47:0] coord;
    logic [47:0] offset;
    logic [3:0]  done;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [11:0] res_mag;
    logic        res_sign;
    logic        busy;

    int checks;
    int failures;

    sign_deduct_sched #(.N_REQ(4), .W(12)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .req       (req),
        .coord     (coord),
        .offset    (offset),
        .done      (done),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_mag   (res_mag),
        .res_sign  (res_sign),
        .busy      (busy)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_op(input int i, input int c, input int o);
        coord[i*12 +: 12]  = 12'(c);
        offset[i*12 +: 12] = 12'(o);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        req   = '0;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        req   = '0;
        step();
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        checks++; if (res_mag !== 12'd0) begin failures++; $display("FAIL reset_mag: got %0d want 0", res_mag); end
        checks++; if (res_id !== 2'd0 || res_sign !== 1'b0) begin failures++; $display("FAIL reset_id_sign: got id=%0d sign=%b want 0/0", res_id, res_sign); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        set_op(2, 100, 30);
        req = 4'b0100;
        step();
        checks++; if (done !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL single_issue: got done=%b busy=%b want 0000/1", done, busy); end
        step();
        checks++; if (done !== 4'b0100 || res_valid !== 1'b1) begin failures++; $display("FAIL single_done: got done=%b valid=%b want 0100/1", done, res_valid); end
        checks++; if (res_mag !== 12'd70 || res_sign !== 1'b0 || res_id !== 2'd2) begin failures++; $display("FAIL single_result: got mag=%0d sign=%b id=%0d want 70/0/2", res_mag, res_sign, res_id); end
        step();
        checks++; if (done !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_clear: got done=%b busy=%b want 0000/0", done, busy); end
        req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (done !== 4'b0000) begin failures++; $display("FAIL single_no_reissue: cycle %0d got done=%b want 0000", k, done); end
        end
    endtask

    task automatic test_neg_equal();
        int          tc[2] = '{5, 2048};
        int          to[2] = '{4095, 2048};
        logic [11:0] em[2] = '{12'd4090, 12'd0};
        logic        es[2] = '{1'b1, 1'b0};
        do_reset();
        for (int v = 0; v < 2; v++) begin
            set_op(v, tc[v], to[v]);
            req = 4'(1 << v);
            step();
            step();
            checks++; if (done !== 4'(1 << v)) begin failures++; $display("FAIL negeq_done%0d: got %b want %b", v, done, 4'(1 << v)); end
            checks++; if (res_mag !== em[v] || res_sign !== es[v]) begin failures++; $display("FAIL negeq_result%0d: got mag=%0d sign=%b want %0d/%b", v, res_mag, res_sign, em[v], es[v]); end
            step();
            req = 4'b0000;
            step();
        end
    endtask

    task automatic test_contention();
        int          tc[4] = '{100, 200, 7, 3000};
        int          to[4] = '{30, 250, 7, 1};
        logic [11:0] em[4] = '{12'd70, 12'd50, 12'd0, 12'd2999};
        logic        es[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, tc[i], to[i]);
        req = 4'b1111;
        step();
        checks++; if (done !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL cont_first_issue: got done=%b busy=%b want 0000/1", done, busy); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (done !== 4'(1 << k) || res_id !== 2'(k)) begin failures++; $display("FAIL cont_order%0d: got done=%b id=%0d want %b/%0d", k, done, res_id, 4'(1 << k), k); end
            checks++; if (res_mag !== em[k] || res_sign !== es[k]) begin failures++; $display("FAIL cont_result%0d: got mag=%0d sign=%b want %0d/%b", k, res_mag, res_sign, em[k], es[k]); end
            req[k] = 1'b0;
        end
        step();
        checks++; if (done !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL cont_idle: got done=%b busy=%b want 0000/0", done, busy); end
    endtask

    task automatic test_back_to_back_reissue();
        logic [3:0] exp_done;
        do_reset();
        set_op(1, 500, 100);
        req = 4'b0010;
        step();
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_done = (k % 3 == 1) ? 4'b0010 : 4'b0000;
            checks++; if (done !== exp_done) begin failures++; $display("FAIL reissue_done_k%0d: got %b want %b", k, done, exp_done); end
            if (k == 1 || k == 4) begin
                checks++; if (res_mag !== 12'd400 || res_sign !== 1'b0) begin failures++; $display("FAIL reissue_old_k%0d: got mag=%0d sign=%b want 400/0", k, res_mag, res_sign); end
            end
            if (k == 4) set_op(1, 100, 600);
            if (k == 7) begin
                checks++; if (res_mag !== 12'd500 || res_sign !== 1'b1) begin failures++; $display("FAIL reissue_new: got mag=%0d sign=%b want 500/1", res_mag, res_sign); end
                req = 4'b0000;
            end
        end
        step();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reissue_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_done[4] = '{4'b0001, 4'b0000, 4'b1000, 4'b0001};
        do_reset();
        set_op(0, 10, 3);
        set_op(3, 4000, 96);
        req = 4'b0001;
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (done !== exp_done[k]) begin failures++; $display("FAIL fair_done_k%0d: got %b want %b", k, done, exp_done[k]); end
            if (k == 0) req[3] = 1'b1;
            if (k == 2) begin
                checks++; if (res_mag !== 12'd3904 || res_id !== 2'd3) begin failures++; $display("FAIL fair_req3: got mag=%0d id=%0d want 3904/3", res_mag, res_id); end
                req[3] = 1'b0;
            end
            if (k == 3) begin
                checks++; if (res_mag !== 12'd7 || res_id !== 2'd0) begin failures++; $display("FAIL fair_wrap: got mag=%0d id=%0d want 7/0", res_mag, res_id); end
                req[0] = 1'b0;
            end
        end
        step();
        checks++; if (busy !== 1'b0 || done !== 4'b0000) begin failures++; $display("FAIL fair_idle: got busy=%b done=%b want 0/0000", busy, done); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_op(0, 100, 30);
        set_op(1, 200, 250);
        req = 4'b0011;
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        RESET = 1'b1;
        #2;
        checks++; if (done !== 4'b0000 || busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL mid_async: got done=%b busy=%b valid=%b want 0000/0/0", done, busy, res_valid); end
        checks++; if (res_mag !== 12'd0 || res_sign !== 1'b0 || res_id !== 2'd0) begin failures++; $display("FAIL mid_async_res: got mag=%0d sign=%b id=%0d want 0/0/0", res_mag, res_sign, res_id); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (done !== 4'b0000) begin failures++; $display("FAIL mid_hold%0d: got done=%b want 0000", k, done); end
        end
        RESET = 1'b0;
        step();
        checks++; if (done !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL mid_reissue: got done=%b busy=%b want 0000/1", done, busy); end
        step();
        checks++; if (done !== 4'b0001 || res_mag !== 12'd70 || res_sign !== 1'b0) begin failures++; $display("FAIL mid_done0: got done=%b mag=%0d sign=%b want 0001/70/0", done, res_mag, res_sign); end
        req[0] = 1'b0;
        step();
        checks++; if (done !== 4'b0010 || res_mag !== 12'd50 || res_sign !== 1'b1) begin failures++; $display("FAIL mid_done1: got done=%b mag=%0d sign=%b want 0010/50/1", done, res_mag, res_sign); end
        req[1] = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b0 || done !== 4'b0000) begin failures++; $display("FAIL mid_idle: got busy=%b done=%b want 0/0000", busy, done); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b1;
        req      = '0;
        coord    = '0;
        offset   = '0;
        step();
        test_reset();
        test_single();
        test_neg_equal();
        test_contention();
        test_back_to_back_reissue();
        test_fairness();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
